// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and IF/ID latch.
// Applies redirects and stalls, squashes the wrong-path word and stops on halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcen,
    input  logic              pcclear,
    input  logic [31:0]       newpc,
    input  logic              halt,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       pc,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_instr,
    output logic              id_valid,
    output logic              halted,
    output logic [15:0]       fetchsum,
    output logic [15:0]       flushsum,
    output logic [15:0]       stallsum
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_nxt_s;
    logic [31:0] id_pc_nxt_s;
    logic [31:0] id_instr_nxt_s;
    logic        id_valid_nxt_s;
    logic        halted_nxt_s;
    logic [15:0] fetchsum_nxt_s;
    logic [15:0] flushsum_nxt_s;
    logic [15:0] stallsum_nxt_s;

    assign imem_addr = pc[ADDR_W+1:2];

    // Next-state and datapath selection; halt outranks stall, which outranks redirect.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc;
        id_pc_nxt_s    = id_pc;
        id_instr_nxt_s = id_instr;
        id_valid_nxt_s = id_valid;
        fetchsum_nxt_s = fetchsum;
        flushsum_nxt_s = flushsum;
        stallsum_nxt_s = stallsum;
        case (state_r)
            BOOT: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_nxt_s    = HALTED;
                    id_pc_nxt_s    = 32'h0000_0000;
                    id_instr_nxt_s = 32'h0000_0000;
                    id_valid_nxt_s = 1'b0;
                end else if (!pcen) begin
                    // A pending redirect stays asserted from the held IF/ID, so it is simply deferred.
                    stallsum_nxt_s = stallsum + 16'd1;
                end else if (pcclear) begin
                    pc_nxt_s       = {newpc[31:2], 2'b00};
                    id_pc_nxt_s    = 32'h0000_0000;
                    id_instr_nxt_s = 32'h0000_0000;
                    id_valid_nxt_s = 1'b0;
                    flushsum_nxt_s = flushsum + 16'd1;
                end else begin
                    pc_nxt_s       = pc + 32'd4;
                    id_pc_nxt_s    = pc;
                    id_instr_nxt_s = imem_rdata;
                    id_valid_nxt_s = 1'b1;
                    fetchsum_nxt_s = fetchsum + 16'd1;
                end
            end
            HALTED: begin
                state_nxt_s = HALTED;
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
        halted_nxt_s = (state_nxt_s == HALTED);
    end

    // State, PC, IF/ID latch and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= BOOT;
            pc       <= RESET_PC;
            id_pc    <= 32'h0000_0000;
            id_instr <= 32'h0000_0000;
            id_valid <= 1'b0;
            halted   <= 1'b0;
            fetchsum <= 16'h0000;
            flushsum <= 16'h0000;
            stallsum <= 16'h0000;
        end else begin
            state_r  <= state_nxt_s;
            pc       <= pc_nxt_s;
            id_pc    <= id_pc_nxt_s;
            id_instr <= id_instr_nxt_s;
            id_valid <= id_valid_nxt_s;
            halted   <= halted_nxt_s;
            fetchsum <= fetchsum_nxt_s;
            flushsum <= flushsum_nxt_s;
            stallsum <= stallsum_nxt_s;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run
// against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcen = 1'b0;
    logic        pcclear = 1'b0;
    logic [31:0] newpc = 32'h0;
    logic        halt = 1'b0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc, id_pc, id_instr;
    logic        id_valid, halted;
    logic [15:0] fetchsum, flushsum, stallsum;

    logic [31:0] rom [0:1023];
    assign imem_rdata = rom[imem_addr];

    int tests_run = 0;
    int tests_failed = 0;

    // model state
    bit          m_boot, m_halted, m_valid;
    logic [31:0] m_pc, m_id_pc, m_instr;
    logic [15:0] m_fetch, m_flush, m_stall;

    fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .pcen(pcen), .pcclear(pcclear), .newpc(newpc),
        .halt(halt), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .halted(halted),
        .fetchsum(fetchsum), .flushsum(flushsum), .stallsum(stallsum)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_boot = 1'b1; m_halted = 1'b0; m_valid = 1'b0;
        m_pc = 32'h0; m_id_pc = 32'h0; m_instr = 32'h0;
        m_fetch = 16'h0; m_flush = 16'h0; m_stall = 16'h0;
    endtask

    task automatic model_step(input logic en, input logic clr, input logic [31:0] np, input logic hlt);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (hlt) begin
            m_halted = 1'b1; m_id_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!en) begin
            m_stall = m_stall + 16'd1;
        end else if (clr) begin
            m_pc = np & 32'hFFFF_FFFC;
            m_id_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_flush = m_flush + 16'd1;
        end else begin
            m_id_pc = m_pc;
            m_instr = rom[(m_pc / 32'd4) % 32'd1024];
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_fetch = m_fetch + 16'd1;
        end
    endtask

    task automatic cycle(input logic en, input logic clr, input logic [31:0] np, input logic hlt);
        pcen = en; pcclear = clr; newpc = np; halt = hlt;
        @(posedge clk);
        model_step(en, clr, np, hlt);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        tests_run++;
        if ({pc, id_pc, id_instr, id_valid, halted, fetchsum, flushsum, stallsum, imem_addr} !==
            {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 10'h0}) begin
            tests_failed++;
            $display("FAIL reset_state: got pc=%h id_pc=%h instr=%h v=%b h=%b sums=%h/%h/%h expected all zero",
                     pc, id_pc, id_instr, id_valid, halted, fetchsum, flushsum, stallsum);
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (id_valid !== 1'b0 || pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL boot_cycle: got id_valid=%b pc=%h expected 0 and 00000000", id_valid, pc);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            tests_run++;
            if (id_pc !== 32'(4 * k) || id_instr !== 32'(k) || id_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL free_run_%0d: got id_pc=%h instr=%h v=%b expected %h %h 1",
                         k, id_pc, id_instr, id_valid, 32'(4 * k), 32'(k));
            end
        end
        tests_run++;
        if (fetchsum !== 16'd3) begin
            tests_failed++;
            $display("FAIL fetchsum_run: got %0d expected 3", fetchsum);
        end
    endtask

    task automatic test_redirect();
        cycle(1'b1, 1'b1, 32'h40, 1'b0);
        tests_run++;
        if (pc !== 32'h40 || id_valid !== 1'b0 || flushsum !== 16'd1) begin
            tests_failed++;
            $display("FAIL redirect_edge1: got pc=%h v=%b flush=%0d expected 00000040 0 1", pc, id_valid, flushsum);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (id_pc !== 32'h40 || id_instr !== 32'd16 || id_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL redirect_edge2: got id_pc=%h instr=%h v=%b expected 00000040 00000010 1", id_pc, id_instr, id_valid);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h80, 1'b0);
        tests_run++;
        if (pc !== 32'h44 || id_pc !== 32'h40 || id_instr !== 32'd16 || stallsum !== 16'd3 || flushsum !== 16'd1) begin
            tests_failed++;
            $display("FAIL stall_hold: got pc=%h id_pc=%h instr=%h stall=%0d flush=%0d expected 44 40 10 3 1",
                     pc, id_pc, id_instr, stallsum, flushsum);
        end
        cycle(1'b1, 1'b1, 32'h80, 1'b0);
        tests_run++;
        if (pc !== 32'h80 || id_valid !== 1'b0 || flushsum !== 16'd2) begin
            tests_failed++;
            $display("FAIL stall_release: got pc=%h v=%b flush=%0d expected 00000080 0 2", pc, id_valid, flushsum);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (id_pc !== 32'h80 || id_instr !== 32'd32) begin
            tests_failed++;
            $display("FAIL stall_target: got id_pc=%h instr=%h expected 00000080 00000020", id_pc, id_instr);
        end
    endtask

    task automatic test_pc_wrap();
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tests_run++;
        if (pc !== 32'hFFFF_FFFC || imem_addr !== 10'h3FF) begin
            tests_failed++;
            $display("FAIL newpc_align: got pc=%h addr=%h expected fffffffc 3ff", pc, imem_addr);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (pc !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'd1023) begin
            tests_failed++;
            $display("FAIL pc_wrap: got pc=%h id_pc=%h instr=%h expected 00000000 fffffffc 000003ff", pc, id_pc, id_instr);
        end
    endtask

    task automatic test_fetch_wrap();
        int n = 0;
        while (m_fetch != 16'hFFFF && n < 70000) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            n++;
        end
        tests_run++;
        if (fetchsum !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL fetchsum_max: got %h expected ffff", fetchsum);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (fetchsum !== 16'h0000) begin
            tests_failed++;
            $display("FAIL fetchsum_wrap: got %h expected 0000", fetchsum);
        end
    endtask

    task automatic test_halt();
        logic [31:0] pc0;
        logic [15:0] f0, l0, s0;
        pc0 = m_pc; f0 = m_fetch; l0 = m_flush; s0 = m_stall;
        cycle(1'b1, 1'b1, 32'h123, 1'b1);
        tests_run++;
        if (halted !== 1'b1 || pc !== pc0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 ||
            fetchsum !== f0 || flushsum !== l0 || stallsum !== s0) begin
            tests_failed++;
            $display("FAIL halt_entry: got h=%b pc=%h v=%b sums=%h/%h/%h expected 1 %h 0 %h/%h/%h",
                     halted, pc, id_valid, fetchsum, flushsum, stallsum, pc0, f0, l0, s0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            tests_run++;
            if (halted !== 1'b1 || pc !== pc0 || id_valid !== 1'b0 ||
                fetchsum !== f0 || flushsum !== l0 || stallsum !== s0) begin
                tests_failed++;
                $display("FAIL halt_hold_%0d: got h=%b pc=%h v=%b sums=%h/%h/%h expected 1 %h 0 %h/%h/%h",
                         i, halted, pc, id_valid, fetchsum, flushsum, stallsum, pc0, f0, l0, s0);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if ({pc, id_pc, id_instr, id_valid, halted, fetchsum, flushsum, stallsum} !==
            {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0}) begin
            tests_failed++;
            $display("FAIL reset_async: got pc=%h h=%b sums=%h/%h/%h expected all zero",
                     pc, halted, fetchsum, flushsum, stallsum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (id_valid !== 1'b0 || pc !== 32'h0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_boot: got v=%b pc=%h h=%b expected 0 00000000 0", id_valid, pc, halted);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        tests_run++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0 || pc !== 32'h4) begin
            tests_failed++;
            $display("FAIL reset_resume: got v=%b id_pc=%h instr=%h pc=%h expected 1 0 0 4", id_valid, id_pc, id_instr, pc);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1024; k++) rom[k] = $urandom;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                model_reset();
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                      $urandom, $urandom_range(0, 99) == 0);
            end
            tests_run++;
            if (pc !== m_pc || id_pc !== m_id_pc || id_instr !== m_instr || id_valid !== m_valid ||
                halted !== m_halted || fetchsum !== m_fetch || flushsum !== m_flush || stallsum !== m_stall) begin
                tests_failed++;
                $display("FAIL random_%0d: got pc=%h id=%h/%h/%b h=%b sums=%h/%h/%h expected pc=%h id=%h/%h/%b h=%b sums=%h/%h/%h",
                         i, pc, id_pc, id_instr, id_valid, halted, fetchsum, flushsum, stallsum,
                         m_pc, m_id_pc, m_instr, m_valid, m_halted, m_fetch, m_flush, m_stall);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) rom[k] = 32'(k);
        model_reset();
        test_reset();
        test_free_run();
        test_redirect();
        test_stall();
        test_pc_wrap();
        test_fetch_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
